// File: rtl/uart_pkg.sv
// Shared UART constants and width helpers used by the baud generator and the rx sampler.
package uart_pkg;

    localparam int unsigned DEFAULT_DIV  = 651;
    localparam int unsigned DEFAULT_FRAC = 0;
    localparam int unsigned MIN_DIV      = 2;
    localparam int unsigned DEFAULT_OVS  = 16;

    // Width of a counter that indexes OVS rx_ticks within one baud period.
    function automatic int unsigned phase_width(input int unsigned ovs);
        return (ovs <= 2) ? 1 : $clog2(ovs);
    endfunction

    // Keeps a zero-width field addressable as a single bit.
    function automatic int unsigned nonzero_w(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_phase_ctr.sv
// OVS-modulo phase counter; zero_c flags the slot that carries the baud (tx) tick.
module uart_phase_ctr
    import uart_pkg::*;
#(
    parameter int unsigned OVS = DEFAULT_OVS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          adv,
    output logic [phase_width(OVS)-1:0]   cnt,
    output logic                          zero_c
);

    localparam int unsigned PH_W = phase_width(OVS);

    logic [PH_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = (cnt_q == PH_W'(OVS - 1)) ? '0 : cnt_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional baud/oversample tick generator: rx_tick at OVS x baud, tx_tick at baud,
// with a shadowed divisor that is only applied on an interval boundary.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OVS          = uart_pkg::DEFAULT_OVS,
    parameter int unsigned DEFAULT_DIV  = uart_pkg::DEFAULT_DIV,
    parameter int unsigned DEFAULT_FRAC = uart_pkg::DEFAULT_FRAC
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [DIV_W-1:0]                 div_in,
    input  logic [nonzero_w(FRAC_W)-1:0]     frac_in,
    input  logic                             div_load,
    output logic                             load_pending,
    output logic                             rx_tick,
    output logic                             tx_tick,
    output logic [phase_width(OVS)-1:0]      phase
);

    localparam int unsigned FW   = nonzero_w(FRAC_W);
    localparam int unsigned PH_W = phase_width(OVS);
    localparam int unsigned CW   = DIV_W + 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_div_q, act_div_d, shd_div_q, shd_div_d;
    logic [FW-1:0]    act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
    logic [FW-1:0]    acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             pend_q, pend_d;
    logic             rx_q, rx_d, tx_q, tx_d;
    logic [PH_W-1:0]  phase_q, phase_d;

    logic [DIV_W-1:0] div_eff_c;
    logic [FW-1:0]    frac_eff_c;
    logic [CW-1:0]    last_cnt_c;
    logic [FW:0]      sum_c;
    logic             terminal_c;
    logic             apply_c;
    logic [PH_W-1:0]  ph_cnt;
    logic             ph_zero_c;

    // Interval arithmetic: clamped divisor, stretch by one when the accumulator overflowed.
    always_comb begin
        div_eff_c  = (act_div_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : act_div_q;
        frac_eff_c = (FRAC_W == 0) ? '0 : act_frac_q;
        last_cnt_c = {1'b0, div_eff_c} + CW'(carry_q) - CW'(1);
        terminal_c = en && ({1'b0, cnt_q} == last_cnt_c);
        sum_c      = {1'b0, acc_q} + {1'b0, frac_eff_c};
        // A load landing on the apply edge supersedes the old shadow and waits its turn.
        apply_c    = pend_q && !div_load && (!en || terminal_c);
    end

    uart_phase_ctr #(
        .OVS (OVS)
    ) u_phase_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!en),
        .adv    (terminal_c),
        .cnt    (ph_cnt),
        .zero_c (ph_zero_c)
    );

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        rx_d       = 1'b0;
        tx_d       = 1'b0;
        phase_d    = phase_q;
        act_div_d  = act_div_q;
        act_frac_d = act_frac_q;
        shd_div_d  = shd_div_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;

        if (!en) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            phase_d = '0;
        end else if (terminal_c) begin
            cnt_d            = '0;
            rx_d             = 1'b1;
            tx_d             = ph_zero_c;
            phase_d          = ph_cnt;
            {carry_d, acc_d} = sum_c;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (apply_c) begin
            act_div_d  = shd_div_q;
            act_frac_d = shd_frac_q;
            pend_d     = 1'b0;
        end

        if (div_load) begin
            shd_div_d  = div_in;
            shd_frac_d = frac_in;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            rx_q       <= 1'b0;
            tx_q       <= 1'b0;
            phase_q    <= '0;
            act_div_q  <= DIV_W'(DEFAULT_DIV);
            act_frac_q <= FW'(DEFAULT_FRAC);
            shd_div_q  <= DIV_W'(DEFAULT_DIV);
            shd_frac_q <= FW'(DEFAULT_FRAC);
            pend_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            phase_q    <= phase_d;
            act_div_q  <= act_div_d;
            act_frac_q <= act_frac_d;
            shd_div_q  <= shd_div_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
        end
    end

    assign rx_tick      = rx_q;
    assign tx_tick      = tx_q;
    assign phase        = phase_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed and randomized checks of uart_baud_gen against an interval-level reference model.
module tb_uart_baud_gen;

    localparam int OVS = 16;
    localparam int FW  = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div_in;
    logic [3:0]  frac_in;
    logic        div_load;
    logic        load_pending;
    logic        rx_tick;
    logic        tx_tick;
    logic [3:0]  phase;

    uart_baud_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_in       (div_in),
        .frac_in      (frac_in),
        .div_load     (div_load),
        .load_pending (load_pending),
        .rx_tick      (rx_tick),
        .tx_tick      (tx_tick),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    int     edge_no = 0;
    string  cur_tag = "init";
    int     tick_at[$];
    int     tx_at[$];

    // Reference model: divisor registers, interval progress and cumulative fraction sum.
    int     m_D, m_F, m_sD, m_sF, m_since, m_k, m_carry;
    bit     m_pend;
    longint m_S;
    logic   e_rx, e_tx, e_pend;
    logic [3:0] e_ph;

    function automatic int eff_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic finish_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic model_reset();
        m_D = 651; m_F = 0; m_sD = 651; m_sF = 0; m_pend = 0;
        m_since = 0; m_k = 0; m_S = 0; m_carry = 0;
        e_rx = 0; e_tx = 0; e_ph = 0; e_pend = 0;
    endtask

    // Tick k after enable lands when the interval (clamped D plus overflow of the running
    // fraction sum) is exhausted; a pending divisor takes effect at the boundary or when idle.
    task automatic model_edge(input logic en_v, input logic ld, input int din, input int fin);
        bit apply;
        apply = m_pend && !ld;
        e_rx = 0;
        e_tx = 0;
        if (!en_v) begin
            m_since = 0; m_k = 0; m_S = 0; m_carry = 0; e_ph = 0;
            if (apply) begin m_D = m_sD; m_F = m_sF; m_pend = 0; end
        end else begin
            m_since++;
            if (m_since == eff_div(m_D) + m_carry) begin
                e_rx = 1;
                e_tx = ((m_k % OVS) == 0);
                e_ph = 4'(m_k % OVS);
                m_k++;
                m_carry = int'(((m_S + longint'(m_F)) >> FW) - (m_S >> FW));
                m_S += longint'(m_F);
                m_since = 0;
                if (apply) begin m_D = m_sD; m_F = m_sF; m_pend = 0; end
            end
        end
        if (ld) begin m_sD = din; m_sF = fin; m_pend = 1; end
        e_pend = m_pend;
    endtask

    task automatic check_outputs();
        n_cmp++;
        assert ({rx_tick, tx_tick, phase, load_pending} === {e_rx, e_tx, e_ph, e_pend})
        else begin
            n_err++;
            $error("FAIL %s edge %0d: rx/tx/phase/pend observed %b/%b/%0d/%b expected %b/%b/%0d/%b",
                   cur_tag, edge_no, rx_tick, tx_tick, phase, load_pending, e_rx, e_tx, e_ph, e_pend);
        end
        if (n_err >= 40) finish_up();
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic mark();
        edge_no = 0;
        tick_at.delete();
        tx_at.delete();
    endtask

    // Drive inputs at the falling edge, clock once, compare after the edge.
    task automatic step(input logic en_v, input logic ld, input int din, input int fin);
        en       = en_v;
        div_load = ld;
        div_in   = 16'(din);
        frac_in  = 4'(fin);
        model_edge(en_v, ld, din, fin);
        @(posedge clk);
        @(negedge clk);
        edge_no++;
        check_outputs();
        if (rx_tick) tick_at.push_back(edge_no);
        if (tx_tick) tx_at.push_back(edge_no);
    endtask

    task automatic run(input logic en_v, input int n);
        for (int i = 0; i < n; i++) step(en_v, 1'b0, 0, 0);
    endtask

    int rd, rf, rl, rev;

    initial begin
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0; frac_in = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        cur_tag = "reset";
        check_outputs();
        rst_n = 1'b1;
        run(1'b0, 2);

        // Defaults: 651-cycle rx period, tx on ticks 1, 17, 33.
        cur_tag = "defaults";
        mark();
        run(1'b1, 651 * 33 + 2);
        chk_int("def_first_rx", q_at(tick_at, 0), 651);
        chk_int("def_second_rx", q_at(tick_at, 1), 1302);
        chk_int("def_tx_count", tx_at.size(), 3);
        chk_int("def_tx17", q_at(tx_at, 1), 17 * 651);
        chk_int("def_tx33", q_at(tx_at, 2), 33 * 651);

        // Fractional 10 + 8/16 loaded while idle.
        cur_tag = "frac";
        step(1'b0, 1'b1, 10, 8);
        run(1'b0, 1);
        mark();
        run(1'b1, 200);
        chk_int("frac_rx3", q_at(tick_at, 2), 31);
        chk_int("frac_rx16", q_at(tick_at, 15), 167);
        chk_int("frac_tx2", q_at(tx_at, 1), q_at(tick_at, 16));

        // Reload mid-interval: current 651 interval completes, then 325.
        cur_tag = "reload";
        step(1'b0, 1'b1, 651, 0);
        run(1'b0, 1);
        mark();
        run(1'b1, 100);
        step(1'b1, 1'b1, 325, 0);
        run(1'b1, 651 - 101 + 325 * 3 + 2);
        chk_int("reload_rx1", q_at(tick_at, 0), 651);
        chk_int("reload_rx2", q_at(tick_at, 1), 976);
        chk_int("reload_rx4", q_at(tick_at, 3), 1626);

        // Divisors below the clamp behave as 2.
        cur_tag = "clamp0";
        step(1'b0, 1'b1, 0, 0);
        run(1'b0, 1);
        mark();
        run(1'b1, 70);
        chk_int("clamp0_rx1", q_at(tick_at, 0), 2);
        chk_int("clamp0_tx2", q_at(tx_at, 1), 34);
        cur_tag = "clamp1";
        step(1'b0, 1'b1, 1, 0);
        run(1'b0, 1);
        mark();
        run(1'b1, 70);
        chk_int("clamp1_rx1", q_at(tick_at, 0), 2);
        chk_int("clamp1_tx2", q_at(tx_at, 1), 34);

        // Enable dropped mid-interval restarts the count and phase.
        cur_tag = "en_drop";
        step(1'b0, 1'b1, 651, 0);
        run(1'b0, 1);
        run(1'b1, 300);
        run(1'b0, 5);
        mark();
        run(1'b1, 660);
        chk_int("reen_rx1", q_at(tick_at, 0), 651);
        chk_int("reen_tx1", q_at(tx_at, 0), 651);

        // Asynchronous reset in the middle of a 325 interval.
        cur_tag = "async_rst";
        run(1'b1, 50);
        step(1'b1, 1'b1, 325, 0);
        run(1'b1, 700);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        mark();
        run(1'b1, 700);
        chk_int("post_rst_rx1", q_at(tick_at, 0), 651);

        // Random divisors, reloads and enable drops.
        cur_tag = "random";
        for (int r = 0; r < 6; r++) begin
            rd = int'($urandom_range(0, 40));
            rf = int'($urandom_range(0, 15));
            step(1'b0, 1'b1, rd, rf);
            run(1'b0, 1);
            for (int i = 0; i < 400; i++) begin
                rl  = int'($urandom_range(0, 49));
                rev = int'($urandom_range(0, 79));
                rd  = int'($urandom_range(0, 40));
                rf  = int'($urandom_range(0, 15));
                step(rev != 0, rl == 0, rd, rf);
            end
        end

        finish_up();
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud/oversample tick generator for the UART. It is the successor to the fixed-ratio divider. Produces an rx_tick at OVS x baud and a tx_tick at baud from the system clock. Adds runtime-programmable integer plus fractional divisor, glitch-free reload, enable and exposed sample phase. Feeds the uart rx sampler and tx shifter.

Parameters:
DIV_W, 16, width of integer divisor (cycles per rx_tick)
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle)
OVS, 16, rx_ticks per tx_tick (power of two, >=2)
DEFAULT_DIV, 651, integer divisor after reset (100 MHz / (9600*16))
DEFAULT_FRAC, 0, fractional divisor after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low holds generator idle
div_in  in  DIV_W  new integer divisor
frac_in  in  FRAC_W  new fractional divisor
div_load  in  1  one-cycle strobe capturing div_in/frac_in
load_pending  out  1  captured divisor not yet applied
rx_tick  out  1  one-cycle pulse, OVS x baud
tx_tick  out  1  one-cycle pulse, baud; coincident with an rx_tick
phase  out  clog2(OVS)  index of most recent rx_tick within baud period

Behaviour:
- Reset (async, rst_n=0): cnt=0, acc=0, phase=0, carry=0, active div/frac=DEFAULT_*, shadow=DEFAULT_*, rx_tick=0, tx_tick=0, load_pending=0.
- All outputs registered. rx_tick and tx_tick are never high two consecutive cycles unless interval=1, which is impossible because of the clamp.
- Effective divisor D = max(active_div, 2).
- Interval length P = D + carry. carry is the overflow of the previous accumulation. The first interval after enable has carry=0.
- cnt counts 0..P-1 on each clk with en=1. The edge where cnt==P-1 is the terminal:
  - cnt<=0; rx_tick<=1.
  - tx_tick<=1 iff phase counter==0; phase<=phase+1 (wraps modulo OVS).
  - {carry,acc} <= acc + active_frac, width FRAC_W+1.
- Ticks: first rx_tick and tx_tick are high in the cycle after the P-th enabled edge. Consecutive rx_ticks are exactly P cycles apart. Mean period = D + frac/2^FRAC_W.
- phase output equals the phase counter value latched at the tick, i.e. 0 on a tx_tick cycle.
- en=0: cnt, acc, carry and phase counter cleared next edge; rx_tick/tx_tick forced 0; active divisor retained.
- Reload:
  - div_load=1 captures div_in/frac_in into shadow and sets load_pending.
  - With en=1, shadow moves to active at the next terminal and load_pending clears. The new divisor governs the interval that starts after that terminal; the current interval completes with the old value.
  - A div_load coincident with a terminal: the old shadow is not applied and the new value waits for the following terminal. No torn or partial interval.
  - With en=0, shadow moves to active on the following edge.
  - A second div_load while pending overwrites the shadow; last write wins.
- div_in<2 is stored as given and clamped to 2 at use. frac is ignored when FRAC_W=0.
- Reset mid-interval aborts immediately: no tick and no partial pulse; the divisor reverts to default.

Decomposition:
- Shared uart_pkg: DEFAULT_DIV/DEFAULT_FRAC constants, MIN_DIV=2, OVS default, and the function computing phase width (clog2).
- The fractional accumulator is small enough to stay inline.
- One natural sub-module: uart_phase_ctr, the OVS-modulo phase counter with tx_tick decode. It is reusable by the rx sampler.

Test Plan:
1. Reset release, en=1, defaults -> rx_tick every 651 cycles; tx_tick at rx_ticks 1, 17, 33 (every 10416 cycles); phase 0 on each tx_tick; load_pending=0.
2. div_load with div_in=10, frac_in=8 while en=0, then en=1 -> rx intervals 10,10,11,10,11,...; 16th rx_tick 167 cycles after enable; tx_tick on 1st and 17th rx_tick.
3. Defaults running; at cnt=100 pulse div_load with div_in=325 -> the current interval stays 651; load_pending high until that terminal; following intervals are 325.
4. div_load with div_in=0, then div_in=1 -> rx_tick every 2 cycles in both cases; tx_tick every 32 cycles.
5. en dropped at cnt=300 and restored 5 cycles later -> no tick while low; first rx_tick and tx_tick 651 cycles after re-enable; phase restarts at 0.
6. rst_n low asynchronously mid-interval, after loading div 325 -> all outputs 0 within the reset; after release the period is 651 (default) and load_pending=0.
